fir_decimator: RTL and testbench
================================

FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 The block SHALL have parameter FILL, default 33, meaning the number of Din samples discarded after reset (FIR pipeline warm-up).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the output FIFO depth in entries; DEPTH is a power of two, 2..64.
REQ-003 The block SHALL have port Clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port Hlt, input, 1, the asynchronous active-high reset.
REQ-005 The block SHALL have port Din, input, 12, the signed FIR output sample, valid every Clk cycle.
REQ-006 The block SHALL have port Decim, input, 4, the decimation factor minus one (factor 1..16).
REQ-007 The block SHALL have port Dout, output, 12, the signed FIFO head sample.
REQ-008 The block SHALL have port Dout_valid, output, 1, high when Dout holds a valid sample.
REQ-009 The block SHALL have port Dout_ready, input, 1, the consumer accept signal.
REQ-010 The block SHALL have port Overflow, output, 1, a sticky flag for a dropped sample.
REQ-011 The block SHALL have port Level, output, 7, the current FIFO occupancy, 0..DEPTH.

Function
REQ-012 The block SHALL implement states WARMUP and RUN; reset enters WARMUP.
REQ-013 In WARMUP, a counter SHALL count Clk edges; Din samples SHALL NOT be stored.
- On the edge where FILL samples have been counted, the state SHALL change to RUN.
- The phase counter SHALL be 0 on entry to RUN.
REQ-014 In RUN, a phase counter SHALL count 0..D, where D is the latched decimation value, then wrap to 0.
- The Din sample present on an edge with phase==0 SHALL be the decimated sample.
REQ-015 Decim SHALL be latched into D on reset exit (value 0 after reset) and on every phase==0 edge.
- A change to Decim therefore takes effect at the next decimation boundary.
- A period in progress SHALL NOT be truncated or extended.
REQ-016 Decimated samples SHALL be pushed into a first-word-fall-through FIFO of DEPTH entries.
REQ-017 Dout SHALL equal the head entry; Dout_valid SHALL equal (Level != 0).
REQ-018 A pop SHALL occur on an edge where Dout_valid and Dout_ready are both high.
- Dout_ready with an empty FIFO SHALL have no effect.
REQ-019 Latency: a sample pushed into an empty FIFO on edge t SHALL appear on Dout with Dout_valid high after edge t, i.e. one cycle.
REQ-020 Simultaneous push and pop SHALL both occur and leave Level unchanged, including when Level==DEPTH and when Level==1.
REQ-021 When Level==DEPTH, a push with no pop in the same cycle SHALL be dropped.
- The FIFO contents SHALL be unchanged.
- Overflow SHALL be set on that edge.
REQ-022 Overflow SHALL remain high until Hlt.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Level SHALL increment on push-only, decrement on pop-only, and be unchanged otherwise.
REQ-025 Dout while Dout_valid is low SHALL hold the last value presented; it is don't-care for checking except after reset.
REQ-026 Data SHALL pass bit-exact with no arithmetic or width change.

Reset
REQ-027 Asserting Hlt SHALL immediately set all of the following:
- Dout=0, Dout_valid=0, Level=0, Overflow=0;
- state=WARMUP, warm-up counter=0, phase=0, D=0;
- FIFO pointers=0.
REQ-028 Hlt asserted mid-operation SHALL discard all FIFO contents; no pop SHALL be counted on that cycle.
REQ-029 After Hlt deasserts, the first stored sample SHALL be the Din present on edge FILL+1 counted from deassertion.

Verification
REQ-030 Warm-up: Din=edge index, Decim=0, Dout_ready=1, FILL=33 -> first Dout=33; then 34, 35, ... one per cycle, Overflow=0.
REQ-031 Decimation: Decim=3 after warm-up, Din ramp -> Dout sequence n, n+4, n+8, ...; Decim changed to 1 mid-period -> current 4-period completes, then 2-period spacing.
REQ-032 Full/overflow: Dout_ready=0, Decim=0, DEPTH=8 -> Level reaches 8 after 8 pushes, 9th sample dropped, Overflow=1 and stays 1; then Dout_ready=1 -> the 8 stored samples emerge in order, with no gap or duplicate.
REQ-033 Simultaneous push/pop at full: Level=8, Dout_ready=1 on a push edge -> Level stays 8, Overflow unchanged at 0.
REQ-034 Backpressure toggle: Dout_ready alternating 1/0 with Decim=1 -> every sample delivered exactly once in order, Level never exceeds 1.
REQ-035 Reset mid-run: Hlt pulsed with Level=5 -> Level=0, Dout_valid=0, Dout=0 asynchronously; after release, 33 samples discarded again.

Source files
------------

// File: rtl/fir_decimator.sv
// Decimator behind a FIR filter: drops FILL warm-up samples, keeps one sample per (D+1)
// cycles and buffers the kept samples in a first-word-fall-through FIFO with a sticky overflow.
module fir_decimator #(
    parameter int unsigned FILL  = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Hlt,
    input  logic [11:0] Din,
    input  logic [3:0]  Decim,
    output logic [11:0] Dout,
    output logic        Dout_valid,
    input  logic        Dout_ready,
    output logic        Overflow,
    output logic [6:0]  Level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(FILL + 1);
    localparam logic [6:0]    DepthL   = 7'(DEPTH);
    localparam logic [CW-1:0] FillLast = CW'(FILL - 1);

    typedef enum logic {StWarmup, StRun} state_e;

    state_e          state_q;
    logic [CW-1:0]   warm_q;
    logic [3:0]      phase_q;
    logic [3:0]      d_q;
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [6:0]      level_q;
    logic            ovf_q;
    logic [11:0]     dout_q;
    logic [11:0]     mem_q [DEPTH];

    logic [3:0]      d_eff;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic [AW-1:0]   rd_nxt;

    always_comb begin
        // A new period takes its length from Decim sampled on its own phase-0 edge.
        d_eff  = (phase_q == '0) ? Decim : d_q;
        push   = (state_q == StRun) && (phase_q == '0);
        pop    = (level_q != '0) && Dout_ready;
        full   = (level_q == DepthL);
        wr_en  = push && (!full || pop);
        rd_nxt = rd_q + AW'(1);
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= Din;
        end
    end

    always_ff @(posedge Clk or posedge Hlt) begin
        if (Hlt) begin
            state_q <= StWarmup;
            warm_q  <= '0;
            phase_q <= '0;
            d_q     <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            unique case (state_q)
                StWarmup: begin
                    if (warm_q == FillLast) begin
                        state_q <= StRun;
                    end else begin
                        warm_q <= warm_q + CW'(1);
                    end
                end
                StRun: begin
                    phase_q <= (phase_q == d_eff) ? 4'd0 : phase_q + 4'd1;
                    if (phase_q == '0) begin
                        d_q <= Decim;
                    end
                end
                default: state_q <= StWarmup;
            endcase

            if (wr_en) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_nxt;
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end

            if (wr_en && !pop) begin
                level_q <= level_q + 7'd1;
            end else if (pop && !wr_en) begin
                level_q <= level_q - 7'd1;
            end

            // Keep the registered head in step with the FIFO; an incoming sample becomes
            // the head directly when the FIFO is (or is about to become) empty.
            if (pop && (level_q > 7'd1)) begin
                dout_q <= mem_q[rd_nxt];
            end else if (wr_en && ((level_q == '0) || ((level_q == 7'd1) && pop))) begin
                dout_q <= Din;
            end
        end
    end

    assign Dout       = dout_q;
    assign Dout_valid = (level_q != '0);
    assign Level      = level_q;
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: random and ramp stimulus compared each cycle with a queue-based
// reference that schedules decimated samples by edge number.
module tb_fir_decimator;

    localparam int FILL  = 33;
    localparam int DEPTH = 8;

    logic        Clk = 1'b0;
    logic        Hlt;
    logic [11:0] Din;
    logic [3:0]  Decim;
    logic [11:0] Dout;
    logic        Dout_valid;
    logic        Dout_ready;
    logic        Overflow;
    logic [6:0]  Level;

    always #5 Clk = ~Clk;

    fir_decimator #(.FILL(FILL), .DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Hlt        (Hlt),
        .Din        (Din),
        .Decim      (Decim),
        .Dout       (Dout),
        .Dout_valid (Dout_valid),
        .Dout_ready (Dout_ready),
        .Overflow   (Overflow),
        .Level      (Level)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference: edges since reset release, edge number of the next kept sample, FIFO contents.
    int          m_edge;
    int          m_next;
    logic [11:0] q[$];
    logic        m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edge = 0;
        m_next = FILL + 1;
        q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic step();
        bit do_pop, do_push, was_full;
        @(posedge Clk);
        m_edge++;
        do_pop   = (q.size() > 0) && Dout_ready;
        was_full = (q.size() == DEPTH);
        do_push  = (m_edge == m_next);
        if (do_push) m_next = m_edge + int'(Decim) + 1;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            if (was_full && !do_pop) m_ovf = 1'b1;
            else q.push_back(Din);
        end
        #1;
        chk("level", Level, q.size());
        chk("valid", Dout_valid, q.size() != 0);
        chk("overflow", Overflow, m_ovf);
        if (q.size() != 0) chk("dout", Dout, q[0]);
    endtask

    task automatic check_reset_state();
        chk("rst_dout", Dout, 0);
        chk("rst_valid", Dout_valid, 0);
        chk("rst_level", Level, 0);
        chk("rst_ovf", Overflow, 0);
    endtask

    initial begin
        Hlt        = 1'b1;
        Din        = '0;
        Decim      = '0;
        Dout_ready = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(negedge Clk);
        Hlt = 1'b0;

        // Warm-up with a ramp: first kept sample is the 34th (index 33).
        for (int i = 0; i < 45; i++) begin
            Dout_ready = 1'b1;
            Decim      = 4'd0;
            Din        = 12'(m_edge);
            step();
            if (m_edge == FILL) chk("warm_empty", Dout_valid, 0);
            if (m_edge == FILL + 1) chk("first_33", Dout, 33);
            if (m_edge == FILL + 3) chk("third_35", Dout, 35);
        end

        // Decimate by 4, then switch to 2 in the middle of a period.
        for (int i = 0; i < 30; i++) begin
            Decim = (i < 10) ? 4'd3 : 4'd1;
            Din   = 12'($urandom);
            step();
        end

        // Fill without consuming.
        Dout_ready = 1'b0;
        Decim      = 4'd0;
        for (int i = 0; i < 40 && q.size() != DEPTH; i++) begin
            Din = 12'($urandom);
            step();
        end
        chk("full_level", Level, DEPTH);

        // Push and pop together at full.
        Dout_ready = 1'b1;
        Din        = 12'($urandom);
        step();
        chk("full_pp_level", Level, DEPTH);
        chk("full_pp_ovf", Overflow, 0);

        // Drop samples at full.
        Dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Din = 12'($urandom);
            step();
        end
        chk("ovf_set", Overflow, 1);

        // Drain with a long period so nothing new arrives meanwhile.
        Dout_ready = 1'b1;
        Decim      = 4'd15;
        for (int i = 0; i < 12; i++) begin
            Din = 12'($urandom);
            step();
        end

        // Alternating backpressure at decimation by 2.
        Decim = 4'd1;
        for (int i = 0; i < 40; i++) begin
            Dout_ready = i[0];
            Din        = 12'($urandom);
            step();
            if (i >= 20) chk("toggle_le1", 32'(Level <= 7'd1), 1);
        end
        chk("ovf_sticky", Overflow, 1);

        // Reset pulse with five entries buffered.
        Dout_ready = 1'b0;
        Decim      = 4'd0;
        for (int i = 0; i < 40 && q.size() != 5; i++) begin
            Din = 12'($urandom);
            step();
        end
        chk("pre_rst_level", Level, 5);
        #2 Hlt = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        @(negedge Clk);
        Hlt = 1'b0;

        for (int i = 0; i < 40; i++) begin
            Dout_ready = 1'b1;
            Decim      = 4'd0;
            Din        = 12'(m_edge);
            step();
            if (m_edge == FILL) chk("rewarm_empty", Dout_valid, 0);
            if (m_edge == FILL + 1) chk("refirst_33", Dout, 33);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
